// File: rtl/stream_downsizer.sv
// Stream downsizer: splits one IN_WIDTH word into up to RATIO OUT_WIDTH slices.
// A word carries its own slice count; last slice handoff accepts the next word.
module stream_downsizer #(
    parameter int unsigned OUT_WIDTH = 8,
    parameter int unsigned RATIO     = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [OUT_WIDTH*RATIO-1:0]        in_data_i,
    input  logic [$clog2(RATIO)-1:0]          in_len_i,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    output logic [OUT_WIDTH-1:0]              out_data_o,
    output logic                              out_last_o,
    output logic                              out_valid_o,
    input  logic                              out_ready_i
);

    localparam int unsigned IN_WIDTH = OUT_WIDTH * RATIO;
    localparam int unsigned LenWidth = $clog2(RATIO);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e              state_q;
    logic [IN_WIDTH-1:0] buf_q;
    logic [LenWidth-1:0] len_q;
    logic [LenWidth-1:0] idx_q;

    logic in_xfer;
    logic out_xfer;

    assign out_valid_o = (state_q == BUSY);
    assign out_last_o  = out_valid_o && (idx_q == len_q);
    assign in_ready_o  = (state_q == IDLE) ||
                         (out_valid_o && out_ready_i && out_last_o);

    assign in_xfer  = in_valid_i && in_ready_o;
    assign out_xfer = out_valid_o && out_ready_i;

    always_comb begin
        out_data_o = '0;
        for (int unsigned k = 0; k < RATIO; k++) begin
            if (idx_q == LenWidth'(k)) begin
                out_data_o = buf_q[k*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    // Input load wins over the last-slice retire so words chain without a bubble.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            buf_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
        end else if (in_xfer) begin
            state_q <= BUSY;
            buf_q   <= in_data_i;
            len_q   <= in_len_i;
            idx_q   <= '0;
        end else if (out_xfer) begin
            if (out_last_o) begin
                state_q <= IDLE;
            end else begin
                idx_q <= idx_q + LenWidth'(1);
            end
        end
    end

`ifndef SYNTHESIS
    a_ratio : assert property (@(posedge clk_i) RATIO >= 2);
    a_width : assert property (@(posedge clk_i) OUT_WIDTH >= 1);

    a_idx : assert property (@(posedge clk_i) disable iff (!rst_ni)
        idx_q <= len_q);

    a_in_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (in_valid_i && !in_ready_o) |=>
        (in_valid_i && $stable(in_data_i) && $stable(in_len_i)));

    a_out_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (out_valid_o && !out_ready_i) |=>
        (out_valid_o && $stable(out_data_o) && $stable(out_last_o)));
`endif

endmodule

// File: tb/tb_stream_downsizer.sv
// Directed bench for stream_downsizer (OUT_WIDTH=8, RATIO=4).
// Vector table for streaming cases, hand sequences for reset corners.
module tb_stream_downsizer;

    logic        clk;
    logic        rst_ni;
    logic [31:0] in_data;
    logic [1:0]  in_len;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;

    int n_chk  = 0;
    int n_fail = 0;

    stream_downsizer #(
        .OUT_WIDTH (8),
        .RATIO     (4)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .in_data_i   (in_data),
        .in_len_i    (in_len),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic [1:0]  len;
        logic        ordy;
        logic        e_rdy;
        logic        e_vld;
        logic        e_last;
        logic        chk_d;
        logic [7:0]  e_d;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic iv, input logic [31:0] d,
                       input logic [1:0] len, input logic ordy,
                       input logic e_rdy, input logic e_vld,
                       input logic e_last, input logic chk_d,
                       input logic [7:0] e_d);
        vec_t v;
        v.iv = iv; v.d = d; v.len = len; v.ordy = ordy;
        v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_last = e_last;
        v.chk_d = chk_d; v.e_d = e_d;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    initial begin
        // Fields: iv d len ordy | e_rdy e_vld e_last chk_d e_d
        // Single word, full length
        add(1, 32'hDDCCBBAA, 3, 1,  1, 0, 0, 0, 8'h00);
        add(0, 32'h0,        0, 1,  0, 1, 0, 1, 8'hAA);
        add(0, 32'h0,        0, 1,  0, 1, 0, 1, 8'hBB);
        add(0, 32'h0,        0, 1,  0, 1, 0, 1, 8'hCC);
        add(0, 32'h0,        0, 1,  1, 1, 1, 1, 8'hDD);
        add(0, 32'h0,        0, 1,  1, 0, 0, 0, 8'h00);
        // Back-to-back words, no bubble
        add(1, 32'h44332211, 3, 1,  1, 0, 0, 0, 8'h00);
        add(1, 32'h88776655, 3, 1,  0, 1, 0, 1, 8'h11);
        add(1, 32'h88776655, 3, 1,  0, 1, 0, 1, 8'h22);
        add(1, 32'h88776655, 3, 1,  0, 1, 0, 1, 8'h33);
        add(1, 32'h88776655, 3, 1,  1, 1, 1, 1, 8'h44);
        add(0, 32'h0,        0, 1,  0, 1, 0, 1, 8'h55);
        add(0, 32'h0,        0, 1,  0, 1, 0, 1, 8'h66);
        add(0, 32'h0,        0, 1,  0, 1, 0, 1, 8'h77);
        add(0, 32'h0,        0, 1,  1, 1, 1, 1, 8'h88);
        add(0, 32'h0,        0, 1,  1, 0, 0, 0, 8'h00);
        // Short word, len=1
        add(1, 32'h44332211, 1, 1,  1, 0, 0, 0, 8'h00);
        add(0, 32'h0,        0, 1,  0, 1, 0, 1, 8'h11);
        add(0, 32'h0,        0, 1,  1, 1, 1, 1, 8'h22);
        add(0, 32'h0,        0, 1,  1, 0, 0, 0, 8'h00);
        // Backpressure holds slice stable
        add(1, 32'hDDCCBBAA, 3, 1,  1, 0, 0, 0, 8'h00);
        add(0, 32'h0,        0, 1,  0, 1, 0, 1, 8'hAA);
        add(0, 32'h0,        0, 0,  0, 1, 0, 1, 8'hBB);
        add(0, 32'h0,        0, 0,  0, 1, 0, 1, 8'hBB);
        add(0, 32'h0,        0, 0,  0, 1, 0, 1, 8'hBB);
        add(0, 32'h0,        0, 1,  0, 1, 0, 1, 8'hBB);
        add(0, 32'h0,        0, 1,  0, 1, 0, 1, 8'hCC);
        add(0, 32'h0,        0, 0,  0, 1, 1, 1, 8'hDD);
        add(0, 32'h0,        0, 1,  1, 1, 1, 1, 8'hDD);
        add(0, 32'h0,        0, 1,  1, 0, 0, 0, 8'h00);
        // len=0 words, chained
        add(1, 32'h000000EE, 0, 1,  1, 0, 0, 0, 8'h00);
        add(1, 32'h0000005A, 0, 1,  1, 1, 1, 1, 8'hEE);
        add(0, 32'h0,        0, 1,  1, 1, 1, 1, 8'h5A);
        add(0, 32'h0,        0, 1,  1, 0, 0, 0, 8'h00);

        // Reset held with a valid word on the input
        rst_ni    = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hFFFFFFFF;
        in_len    = 2'd3;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_ready", {31'b0, in_ready},  32'd1);
        chk("rst_last",  {31'b0, out_last},  32'd0);
        chk("rst_data",  {24'b0, out_data},  32'h00);
        @(negedge clk);
        rst_ni   = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("post_rst_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        #1;
        chk("post_rst_idle", {31'b0, out_valid}, 32'd0);
        chk("post_rst_data", {24'b0, out_data},  32'h00);

        foreach (vq[i]) begin
            @(negedge clk);
            in_valid  = vq[i].iv;
            in_data   = vq[i].d;
            in_len    = vq[i].len;
            out_ready = vq[i].ordy;
            #1;
            chk($sformatf("v%0d_ready", i), {31'b0, in_ready},
                {31'b0, vq[i].e_rdy});
            chk($sformatf("v%0d_valid", i), {31'b0, out_valid},
                {31'b0, vq[i].e_vld});
            chk($sformatf("v%0d_last", i), {31'b0, out_last},
                {31'b0, vq[i].e_last});
            if (vq[i].chk_d)
                chk($sformatf("v%0d_data", i), {24'b0, out_data},
                    {24'b0, vq[i].e_d});
        end

        // Reset mid-word discards the remaining slices
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 32'hDDCCBBAA;
        in_len    = 2'd3;
        out_ready = 1'b1;
        #1;
        chk("mid_load_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("mid_aa", {24'b0, out_data}, 32'hAA);
        @(negedge clk);
        #1;
        chk("mid_bb", {24'b0, out_data}, 32'hBB);
        @(negedge clk);
        #1;
        chk("mid_cc", {24'b0, out_data}, 32'hCC);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_ready", {31'b0, in_ready},  32'd1);
        chk("mid_rst_last",  {31'b0, out_last},  32'd0);
        chk("mid_rst_data",  {24'b0, out_data},  32'h00);
        @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        #1;
        chk("mid_rel_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'h04030201;
        in_len   = 2'd3;
        #1;
        chk("new_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("new_valid", {31'b0, out_valid}, 32'd1);
        chk("new_first", {24'b0, out_data},  32'h01);
        chk("new_last",  {31'b0, out_last},  32'd0);
        @(negedge clk);
        #1;
        chk("new_second", {24'b0, out_data}, 32'h02);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
